// File: rtl/tt_um_serial_deserializer.sv
// rtl/tt_um_serial_deserializer.sv - framed serial-to-parallel receiver with valid/ack handshake
module tt_um_serial_deserializer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0] hist_q;
  logic [2:0] synced;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, data_q, data_d, shifted;
  logic       dir_q, dir_d;
  logic       valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic       stb_rise, frame_rise, frame_fall, sdata, ack;
  logic       complete, err_set;
  logic       unused_ok;

  assign synced     = sync_q[SYNC_STAGES-1];
  assign sdata      = synced[0];
  assign stb_rise   = synced[1] & ~hist_q[1];
  assign frame_rise = synced[2] & ~hist_q[2];
  assign frame_fall = ~synced[2] & hist_q[2];
  assign ack        = uio_in[4];
  assign unused_ok  = &{1'b0, ui_in[7:4], uio_in[7:5], uio_in[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else if (ena) begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ui_in[2:0]};
      hist_q  <= synced;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    data_d   = data_q;
    dir_d    = dir_q;
    complete = 1'b0;
    err_set  = 1'b0;
    shifted  = dir_q ? {sdata, sr_q[7:1]} : {sr_q[6:0], sdata};
    case (state_q)
      IDLE: begin
        // DIR is sampled raw here; the sender keeps it static around FRAME rise
        if (frame_rise) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
          dir_d   = ui_in[3];
        end
      end
      SHIFT: begin
        // A final bit coinciding with FRAME fall still completes cleanly
        if (stb_rise && cnt_q == 3'd7) begin
          complete = 1'b1;
          sr_d     = shifted;
          data_d   = shifted;
          cnt_d    = cnt_q + 3'd1;
          state_d  = frame_fall ? IDLE : WAIT_END;
        end else if (frame_fall) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else if (stb_rise) begin
          sr_d  = shifted;
          cnt_d = cnt_q + 3'd1;
        end
      end
      WAIT_END: begin
        if (stb_rise)   err_set = 1'b1;
        if (frame_fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = complete | (valid_q & ~ack);
    ovr_d   = (complete & valid_q & ~ack) | (ovr_q & ~ack);
    ferr_d  = err_set | (ferr_q & ~ack);
  end

  assign uo_out  = data_q;
  assign uio_out = {4'b0000, ferr_q, (state_q != IDLE), ovr_q, valid_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_serial_deserializer.sv
// tb/tb_tt_um_serial_deserializer.sv - self-checking bench for the serial deserializer
module tb_tt_um_serial_deserializer;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic sdata = 1'b0, stb = 1'b0, frame = 1'b0, dir = 1'b0, ack = 1'b0;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  int total = 0;
  int bad = 0;

  logic [7:0] m_data;
  logic m_valid, m_ovr, m_ferr;

  typedef struct {
    logic       dir;
    logic [7:0] seq;
    logic       ack_first;
    logic [7:0] exp_data;
    logic       exp_ovr;
  } vec_t;
  vec_t vecs[6];

  assign ui_in  = {4'b0000, dir, frame, stb, sdata};
  assign uio_in = {3'b000, ack, 4'b0000};

  always #5 clk = ~clk;

  tt_um_serial_deserializer #(.SYNC_STAGES(S)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic [7:0] d, input logic v,
                           input logic o, input logic b, input logic f);
    chk({name, ".data"}, uo_out, d);
    chk({name, ".flags"}, {4'b0, uio_out[3:0]}, {4'b0, f, b, o, v});
  endtask

  task automatic pulse_bit(input logic b);
    sdata = b;
    @(negedge clk);
    stb = 1'b1;
    repeat (S + 2) @(negedge clk);
    stb = 1'b0;
    repeat (S + 2) @(negedge clk);
  endtask

  task automatic start_frame(input logic d);
    dir = d;
    frame = 1'b1;
    repeat (S + 3) @(negedge clk);
  endtask

  task automatic end_frame();
    frame = 1'b0;
    repeat (S + 2) @(negedge clk);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  function automatic logic [7:0] ref_word(input logic d, input logic [7:0] seq);
    int v = 0;
    for (int i = 0; i < 8; i++) begin
      int b = seq[7-i];
      if (!d) v = v * 2 + b;
      else    v = v + (b << i);
    end
    return v[7:0];
  endfunction

  task automatic full_frame(input logic d, input logic [7:0] seq);
    start_frame(d);
    for (int i = 7; i >= 0; i--) pulse_bit(seq[i]);
    end_frame();
    m_ovr   = m_ovr | m_valid;
    m_valid = 1'b1;
    m_data  = ref_word(d, seq);
  endtask

  initial begin
    logic [7:0] seq;
    logic       d, af;
    vecs[0] = '{1'b0, 8'hB2, 1'b0, 8'hB2, 1'b0};
    vecs[1] = '{1'b1, 8'hB2, 1'b0, 8'h4D, 1'b1};
    vecs[2] = '{1'b0, 8'h3C, 1'b1, 8'h3C, 1'b0};
    vecs[3] = '{1'b1, 8'h01, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{1'b1, 8'hF0, 1'b0, 8'h0F, 1'b1};
    vecs[5] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0};
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;

    repeat (3) @(negedge clk);
    chk_flags("reset", 8'h00, 0, 0, 0, 0);
    chk("oe", uio_oe, 8'h0F);
    rst_n = 1'b1;
    @(negedge clk);

    // MSB-first with exact completion latency
    start_frame(1'b0);
    seq = 8'hB2;
    for (int i = 7; i >= 1; i--) pulse_bit(seq[i]);
    sdata = seq[0];
    @(negedge clk);
    stb = 1'b1;
    repeat (S) @(negedge clk);
    chk("msb.latency_early", {7'b0, uio_out[0]}, 8'h00);
    @(negedge clk);
    chk_flags("msb.complete", 8'hB2, 1, 0, 1, 0);
    repeat (S + 2) @(negedge clk);
    stb = 1'b0;
    repeat (S + 2) @(negedge clk);
    chk("msb.busy_hold", {7'b0, uio_out[2]}, 8'h01);
    end_frame();
    chk_flags("msb.end", 8'hB2, 1, 0, 0, 0);

    // Overrun, then ACK clears everything
    full_frame(1'b0, 8'h3C);
    chk_flags("overrun", 8'h3C, 1, 1, 0, 0);
    do_ack();
    chk_flags("overrun.ack", 8'h3C, 0, 0, 0, 0);

    // LSB-first then ACK
    full_frame(1'b1, 8'hB2);
    chk_flags("lsb", 8'h4D, 1, 0, 0, 0);
    do_ack();
    chk_flags("lsb.ack", 8'h4D, 0, 0, 0, 0);

    // Abort after 5 bits
    start_frame(1'b0);
    for (int i = 0; i < 5; i++) pulse_bit(1'b1);
    end_frame();
    chk_flags("abort", 8'h4D, 0, 0, 0, 1);
    do_ack();

    // Ninth strobe while waiting for FRAME fall
    start_frame(1'b0);
    for (int i = 7; i >= 0; i--) pulse_bit(seq[i]);
    pulse_bit(1'b1);
    chk_flags("ninth", 8'hB2, 1, 0, 1, 1);
    end_frame();
    do_ack();

    // Reset in the middle of a frame
    start_frame(1'b0);
    for (int i = 0; i < 4; i++) pulse_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.uo_out", uo_out, 8'h00);
    chk("rst.uio_out", uio_out, 8'h00);
    frame = 1'b0;
    stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_frame(1'b0, 8'hA5);
    chk_flags("rst.refill", 8'hA5, 1, 0, 0, 0);
    do_ack();

    // FRAME fall together with the eighth strobe
    start_frame(1'b1);
    seq = 8'h96;
    for (int i = 7; i >= 1; i--) pulse_bit(seq[i]);
    sdata = seq[0];
    @(negedge clk);
    stb = 1'b1;
    frame = 1'b0;
    repeat (S + 2) @(negedge clk);
    chk_flags("fall_with_last", ref_word(1'b1, 8'h96), 1, 0, 0, 0);
    stb = 1'b0;
    repeat (S + 2) @(negedge clk);
    do_ack();

    // Strobe lost while disabled
    start_frame(1'b0);
    seq = 8'hC9;
    for (int i = 7; i >= 5; i--) pulse_bit(seq[i]);
    ena = 1'b0;
    @(negedge clk);
    sdata = 1'b1;
    stb = 1'b1;
    repeat (4) @(negedge clk);
    stb = 1'b0;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    for (int i = 4; i >= 1; i--) pulse_bit(seq[i]);
    chk_flags("ena.seven", ref_word(1'b1, 8'h96), 0, 0, 1, 0);
    pulse_bit(seq[0]);
    end_frame();
    chk_flags("ena.complete", 8'hC9, 1, 0, 0, 0);

    // ACK lands on the completion edge
    start_frame(1'b0);
    seq = 8'h5E;
    for (int i = 7; i >= 1; i--) pulse_bit(seq[i]);
    sdata = seq[0];
    @(negedge clk);
    stb = 1'b1;
    repeat (S) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk_flags("ack_same", 8'h5E, 1, 0, 1, 0);
    repeat (S + 2) @(negedge clk);
    stb = 1'b0;
    repeat (S + 2) @(negedge clk);
    end_frame();
    do_ack();

    // Table vectors
    for (int k = 0; k < 6; k++) begin
      if (vecs[k].ack_first) do_ack();
      full_frame(vecs[k].dir, vecs[k].seq);
      chk_flags($sformatf("vec%0d", k), vecs[k].exp_data, 1, vecs[k].exp_ovr, 0, 0);
    end

    // Randomized frames against the reference model
    for (int k = 0; k < 20; k++) begin
      d   = 1'($urandom_range(0, 1));
      af  = 1'($urandom_range(0, 1));
      seq = 8'($urandom);
      if (af) do_ack();
      full_frame(d, seq);
      chk_flags($sformatf("rnd%0d", k), m_data, m_valid, m_ovr, 0, m_ferr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
